// File: rtl/rx_frame_sync_pkg.sv
// rx_frame_sync_pkg: sync word, state encodings and stream width shared by the Rx deframer and Tx framer
package rx_frame_sync_pkg;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;
    localparam int          BYTE_W            = 8;

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

endpackage

// File: rtl/rx_frame_sync_if.sv
// rx_frame_sync_if: byte stream carrying recovered payload, no backpressure
interface rx_frame_sync_if;
    import rx_frame_sync_pkg::*;

    logic [BYTE_W-1:0] tdata;
    logic              tvalid;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast);
    modport slave  (input  tdata, tvalid, tuser, tlast);

endinterface

// File: rtl/rx_frame_sync_sync_correlator.sv
// rx_frame_sync_sync_correlator: combinational Hamming-distance match of a window against the sync word and its complement
module rx_frame_sync_sync_correlator
    import rx_frame_sync_pkg::*;
#(
    parameter int          SYNC_LEN  = 32,
    parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int          MAX_ERR   = 2
) (
    input  logic [SYNC_LEN-1:0] window,
    output logic                match_pos,
    output logic                match_neg
);

    localparam int DW = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] diff;
    logic [DW-1:0]       dist_pos;
    logic [DW-1:0]       dist_neg;

    assign diff = window ^ SYNC_WORD[SYNC_LEN-1:0];

    // Popcount of the mismatch; distance to the complement is what is left over
    always_comb begin
        dist_pos = '0;
        for (int i = 0; i < SYNC_LEN; i++) dist_pos = dist_pos + DW'(diff[i]);
        dist_neg = DW'(SYNC_LEN) - dist_pos;
    end

    assign match_pos = dist_pos <= DW'(MAX_ERR);
    assign match_neg = dist_neg <= DW'(MAX_ERR);

endmodule

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: error-tolerant sync hunt with 180-degree ambiguity fix, packs payload MSB-first into bytes
module rx_frame_sync
    import rx_frame_sync_pkg::*;
#(
    parameter int          SYNC_LEN      = 32,
    parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int          MAX_ERR       = 2,
    parameter int          PAYLOAD_BYTES = 16,
    parameter int          GAP_MAX       = 64
) (
    input  logic              clk_1M024,
    input  logic              rst_n_1M024,
    input  logic              Rx_1bit,
    input  logic              Rx_vld,
    rx_frame_sync_if.master   data,
    output logic              locked,
    output logic              inverted,
    output logic              frame_err
);

    localparam int FW = $clog2(SYNC_LEN + 1);

    logic [0:0]          state;
    logic [SYNC_LEN-2:0] sr;
    logic [SYNC_LEN-1:0] win;
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fill_next;
    logic [BYTE_W-1:0]   byte_sr;
    logic [BYTE_W-1:0]   byte_next;
    logic [7:0]          bytecnt;
    logic [7:0]          gapcnt;
    logic [7:0]          gap_next;
    logic [2:0]          bitcnt;
    logic                match_pos;
    logic                match_neg;
    logic                primed;

    assign win       = {sr, Rx_1bit};
    assign fill_next = (fill == FW'(SYNC_LEN)) ? fill : fill + 1'b1;
    assign primed    = fill_next == FW'(SYNC_LEN);
    assign byte_next = {byte_sr[BYTE_W-2:0], Rx_1bit ^ inverted};
    assign gap_next  = gapcnt + 8'd1;
    assign locked    = state == ST_PAYLOAD;

    rx_frame_sync_sync_correlator #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD),
        .MAX_ERR   (MAX_ERR)
    ) u_corr (
        .window    (win),
        .match_pos (match_pos),
        .match_neg (match_neg)
    );

    // Hunt/payload sequencing; the sync history is wiped on lock so the next hunt starts from empty
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            state       <= ST_HUNT;
            sr          <= '0;
            fill        <= '0;
            byte_sr     <= '0;
            bitcnt      <= '0;
            bytecnt     <= '0;
            gapcnt      <= '0;
            inverted    <= 1'b0;
            frame_err   <= 1'b0;
            data.tdata  <= '0;
            data.tvalid <= 1'b0;
            data.tuser  <= 1'b0;
            data.tlast  <= 1'b0;
        end else begin
            data.tvalid <= 1'b0;
            data.tuser  <= 1'b0;
            data.tlast  <= 1'b0;
            frame_err   <= 1'b0;
            if (state == ST_HUNT) begin
                if (Rx_vld) begin
                    sr   <= win[SYNC_LEN-2:0];
                    fill <= fill_next;
                    if (primed && (match_pos || match_neg)) begin
                        state    <= ST_PAYLOAD;
                        inverted <= !match_pos;
                        sr       <= '0;
                        fill     <= '0;
                        bitcnt   <= '0;
                        bytecnt  <= '0;
                        gapcnt   <= '0;
                    end
                end
            end else if (Rx_vld) begin
                byte_sr <= byte_next;
                bitcnt  <= bitcnt + 3'd1;
                gapcnt  <= '0;
                if (bitcnt == 3'd7) begin
                    data.tdata  <= byte_next;
                    data.tvalid <= 1'b1;
                    data.tuser  <= bytecnt == 8'd0;
                    data.tlast  <= bytecnt == 8'(PAYLOAD_BYTES - 1);
                    bytecnt     <= bytecnt + 8'd1;
                    if (bytecnt == 8'(PAYLOAD_BYTES - 1)) state <= ST_HUNT;
                end
            end else begin
                gapcnt <= gap_next;
                if (gap_next == 8'(GAP_MAX)) begin
                    frame_err <= 1'b1;
                    state     <= ST_HUNT;
                    byte_sr   <= '0;
                    bitcnt    <= '0;
                    bytecnt   <= '0;
                    gapcnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: randomized and directed frames checked cycle by cycle against a queue-based reference model
module tb_rx_frame_sync;
    import rx_frame_sync_pkg::*;

    localparam logic [31:0] SW = 32'h1ACFFC1D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_bit = 1'b0;
    logic rx_vld = 1'b0;
    logic locked, inverted, frame_err;

    rx_frame_sync_if dif();

    always #5 clk = ~clk;

    rx_frame_sync dut (
        .clk_1M024   (clk),
        .rst_n_1M024 (rst_n),
        .Rx_1bit     (rx_bit),
        .Rx_vld      (rx_vld),
        .data        (dif),
        .locked      (locked),
        .inverted    (inverted),
        .frame_err   (frame_err)
    );

    int checks = 0;
    int errors = 0;
    int s_tv, s_tu, s_tl, s_fe;

    bit         m_lock, m_inv, m_tv, m_tu, m_tl, m_fe;
    logic [7:0] m_td;
    bit         hist[$];
    bit         pbits[$];
    int         nbytes, gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_inv = 0; m_tv = 0; m_tu = 0; m_tl = 0; m_fe = 0; m_td = '0;
        hist.delete(); pbits.delete(); nbytes = 0; gap = 0;
    endtask

    task automatic model_step(input bit v, input bit b);
        logic [31:0] w;
        logic [7:0]  by;
        m_tv = 0; m_tu = 0; m_tl = 0; m_fe = 0;
        if (!m_lock) begin
            if (v) begin
                hist.push_back(b);
                if (hist.size() > 32) void'(hist.pop_front());
                if (hist.size() == 32) begin
                    w = '0;
                    foreach (hist[i]) w = {w[30:0], hist[i]};
                    if ($countones(w ^ SW) <= 2) begin m_lock = 1; m_inv = 0; end
                    else if ($countones(~w ^ SW) <= 2) begin m_lock = 1; m_inv = 1; end
                    if (m_lock) begin hist.delete(); pbits.delete(); nbytes = 0; gap = 0; end
                end
            end
        end else if (v) begin
            pbits.push_back(b ^ m_inv);
            gap = 0;
            if (pbits.size() == 8) begin
                by = '0;
                foreach (pbits[i]) by = {by[6:0], pbits[i]};
                m_td = by; m_tv = 1; m_tu = nbytes == 0; m_tl = nbytes == 15;
                nbytes++;
                pbits.delete();
                if (nbytes == 16) m_lock = 0;
            end
        end else begin
            gap++;
            if (gap == 64) begin m_fe = 1; m_lock = 0; pbits.delete(); hist.delete(); end
        end
    endtask

    task automatic cyc(input bit v, input bit b);
        rx_vld = v;
        rx_bit = b;
        @(posedge clk);
        model_step(v, b);
        #1;
        check("tvalid", dif.tvalid, m_tv);
        check("tuser", dif.tuser, m_tu);
        check("tlast", dif.tlast, m_tl);
        check("tdata", dif.tdata, m_td);
        check("frame_err", frame_err, m_fe);
        check("locked", locked, m_lock);
        check("inverted", inverted, m_inv);
        s_tv += dif.tvalid; s_tu += dif.tuser; s_tl += dif.tlast; s_fe += frame_err;
    endtask

    task automatic send_bit(input bit b, input int sparse);
        repeat (sparse) cyc(1'b0, 1'($urandom));
        cyc(1'b1, b);
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int sparse);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], sparse);
    endtask

    task automatic send_frame(input bit inv, input int flips, input int sparse, input int nb, input bit rnd);
        logic [31:0] mask = '0;
        logic [31:0] d;
        while ($countones(mask) < flips) mask[$urandom_range(31, 0)] = 1'b1;
        send_word(32'hA5 ^ {32{inv}}, 8, sparse);
        send_word(SW ^ mask ^ {32{inv}}, 32, sparse);
        for (int i = 0; i < nb; i++) begin
            d = rnd ? 32'($urandom) : 32'(i);
            send_word(d ^ {32{inv}}, 8, sparse);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_tvalid", dif.tvalid, 0);
        check("rst_tuser", dif.tuser, 0);
        check("rst_tlast", dif.tlast, 0);
        check("rst_tdata", dif.tdata, 0);
        check("rst_locked", locked, 0);
        check("rst_inverted", inverted, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_tv = 0; s_tu = 0; s_tl = 0; s_fe = 0;
    endtask

    initial begin
        do_reset();
        send_frame(0, 0, 0, 16, 0);
        check("clean_tv", s_tv, 16);
        check("clean_tu", s_tu, 1);
        check("clean_tl", s_tl, 1);
        check("clean_inv", inverted, 0);
        check("clean_unlock", locked, 0);

        do_reset();
        send_frame(1, 0, 0, 16, 0);
        check("inv_tv", s_tv, 16);
        check("inv_flag", inverted, 1);

        do_reset();
        send_frame(0, 2, 0, 16, 0);
        check("err2_tv", s_tv, 16);
        check("err2_tl", s_tl, 1);

        do_reset();
        send_frame(0, 3, 0, 16, 0);
        check("err3_tv", s_tv, 0);

        do_reset();
        send_frame(0, 0, 31, 16, 0);
        check("sparse_tv", s_tv, 16);
        check("sparse_tl", s_tl, 1);

        do_reset();
        send_frame(0, 0, 0, 6, 0);
        repeat (64) cyc(1'b0, 1'b0);
        check("gap_fe", s_fe, 1);
        check("gap_tl", s_tl, 0);
        send_frame(0, 0, 0, 16, 0);
        check("gap_tv", s_tv, 22);
        check("gap_tu", s_tu, 2);
        check("gap_tl2", s_tl, 1);

        do_reset();
        send_frame(0, 0, 0, 3, 0);
        check("mid_locked", locked, 1);
        do_reset();
        send_word(~SW >> 1, 31, 0);
        check("prime_nolock", locked, 0);
        send_word(32'h0, 1, 0);
        check("prime_lock", locked, 1);
        for (int i = 0; i < 16; i++) send_word(32'h0, 8, 0);
        check("prime_tv", s_tv, 16);
        check("prime_inv", inverted, 1);

        for (int k = 0; k < 8; k++) begin
            do_reset();
            send_frame(1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), 16, 1'b1);
            send_word(32'($urandom), 32, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
